// File: rtl/nonce_dispatch_ctrl.sv
// rtl/nonce_dispatch_ctrl.sv - nonce search job sequencer for the hash validator pipeline
//
// Accepts one job at a time: a compact difficulty and an inclusive nonce range.
// It issues one nonce per cycle into the hash pipeline, tracks the results that
// come back, and reports the winning nonce, range exhaustion or abort completion.
//
// Optional feature macro: MULTI_HIT_EN
//   defined   : issue continues after a hit; every hit pulses found_o; adds hit_count_o
//   undefined : the first hit stops issue; later hits are ignored
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   job_valid_i          job offer, taken when job_ready_o is high
//   job_ready_o          high only while idle
//   job_difficulty_i     compact target {exp[31:24], mantissa[23:0]}
//   job_nonce_start_i    first nonce (inclusive)
//   job_nonce_end_i      last nonce (inclusive); end < start means start only
//   abort_i              stop the current job and discard in-flight results
//   pipe_valid_o         nonce beat into the pipeline
//   pipe_newblock_o      marks the first beat of a job
//   pipe_nonce_o         nonce of this beat
//   pipe_difficulty_o    difficulty held for the whole job
//   res_valid_i          result beat from the validator
//   res_newblock_i       result belongs to a first beat
//   res_success_i        result met the target
//   found_o              one-cycle pulse per accepted hit
//   found_nonce_o        nonce of the latest hit, cleared on job accept
//   done_o               one-cycle pulse once the job has fully drained
//   exhausted_o          range finished without a hit, held until next accept
//   hit_count_o          (MULTI_HIT_EN only) saturating hit count for the job

module nonce_dispatch_ctrl #(
    parameter int PIPE_DEPTH = 64,
    parameter int NONCE_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               job_valid_i,
    output logic               job_ready_o,
    input  logic [31:0]        job_difficulty_i,
    input  logic [NONCE_W-1:0] job_nonce_start_i,
    input  logic [NONCE_W-1:0] job_nonce_end_i,
    input  logic               abort_i,
    output logic               pipe_valid_o,
    output logic               pipe_newblock_o,
    output logic [NONCE_W-1:0] pipe_nonce_o,
    output logic [31:0]        pipe_difficulty_o,
    input  logic               res_valid_i,
    input  logic               res_newblock_i,
    input  logic               res_success_i,
    output logic               found_o,
    output logic [NONCE_W-1:0] found_nonce_o,
    output logic               done_o,
    output logic               exhausted_o
`ifdef MULTI_HIT_EN
    ,
    output logic [15:0]        hit_count_o
`endif
);

    localparam int CW = $clog2(PIPE_DEPTH + 2) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t             state;
    logic [NONCE_W-1:0] nonce_q;       // next nonce to issue
    logic [NONCE_W-1:0] last_q;        // last nonce of the range
    logic [NONCE_W-1:0] start_q;
    logic [NONCE_W-1:0] ret_next_q;    // nonce expected on the next returning result
    logic [31:0]        diff_q;
    logic [CW-1:0]      out_cnt;
    logic               first_q;       // next beat is the newblock beat
    logic               armed_q;       // newblock beat of this job has been issued
    logic               in_epoch_q;    // newblock result of this job has returned
    logic               hit_seen_q;
    logic               aborted_q;
    logic               last_issued_q;

    logic               issue;
    logic               last_beat;
    logic               epoch_start;
    logic               res_counted;
    logic [NONCE_W-1:0] ret_nonce;
    logic               suppress;
    logic               hit;
    logic               stop_on_hit;
    logic [CW-1:0]      out_next;

    // Abort blocks the beat of the very cycle it arrives in, so issue is
    // gated combinationally rather than taken from a register.
    assign issue             = (state == S_RUN) && !abort_i;
    assign last_beat         = issue && (nonce_q == last_q);
    assign job_ready_o       = (state == S_IDLE);
    assign pipe_valid_o      = issue;
    assign pipe_newblock_o   = issue && first_q;
    assign pipe_nonce_o      = nonce_q;
    assign pipe_difficulty_o = diff_q;

    // A job's results start at its own newblock result. Anything earlier is a
    // leftover of a reset-interrupted job: its beats were never counted here,
    // so it neither reports hits nor touches the outstanding counter.
    assign epoch_start = res_valid_i && res_newblock_i && armed_q && !in_epoch_q;
    assign res_counted = res_valid_i && (in_epoch_q || epoch_start);
    assign ret_nonce   = epoch_start ? start_q : ret_next_q;

    assign suppress = aborted_q || (abort_i && (state != S_IDLE));

`ifdef MULTI_HIT_EN
    assign stop_on_hit = 1'b0;
    assign hit = res_counted && res_success_i && !suppress && (state != S_IDLE);
`else
    assign stop_on_hit = hit;
    assign hit = res_counted && res_success_i && !suppress && !hit_seen_q
                 && (state != S_IDLE);
`endif

    assign out_next = out_cnt + CW'(issue) - CW'(res_counted);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            nonce_q       <= '0;
            last_q        <= '0;
            start_q       <= '0;
            ret_next_q    <= '0;
            diff_q        <= '0;
            out_cnt       <= '0;
            first_q       <= 1'b0;
            armed_q       <= 1'b0;
            in_epoch_q    <= 1'b0;
            hit_seen_q    <= 1'b0;
            aborted_q     <= 1'b0;
            last_issued_q <= 1'b0;
            found_o       <= 1'b0;
            found_nonce_o <= '0;
            done_o        <= 1'b0;
            exhausted_o   <= 1'b0;
`ifdef MULTI_HIT_EN
            hit_count_o   <= '0;
`endif
        end else begin
            found_o <= 1'b0;
            done_o  <= 1'b0;
            out_cnt <= out_next;

            if (res_counted) begin
                ret_next_q <= ret_nonce + 1'b1;
            end
            if (epoch_start) begin
                in_epoch_q <= 1'b1;
            end

            // The increment past the last nonce may wrap, but it is never issued.
            if (issue) begin
                nonce_q <= nonce_q + 1'b1;
                first_q <= 1'b0;
                if (first_q) begin
                    armed_q <= 1'b1;
                end
            end
            if (last_beat) begin
                last_issued_q <= 1'b1;
            end

            if (hit) begin
                found_o       <= 1'b1;
                found_nonce_o <= ret_nonce;
                hit_seen_q    <= 1'b1;
`ifdef MULTI_HIT_EN
                if (hit_count_o != 16'hFFFF) begin
                    hit_count_o <= hit_count_o + 16'd1;
                end
`endif
            end

            case (state)
                S_IDLE: begin
                    if (job_valid_i) begin
                        state         <= S_RUN;
                        diff_q        <= job_difficulty_i;
                        start_q       <= job_nonce_start_i;
                        nonce_q       <= job_nonce_start_i;
                        last_q        <= (job_nonce_end_i < job_nonce_start_i) ?
                                         job_nonce_start_i : job_nonce_end_i;
                        first_q       <= 1'b1;
                        armed_q       <= 1'b0;
                        in_epoch_q    <= 1'b0;
                        hit_seen_q    <= 1'b0;
                        aborted_q     <= 1'b0;
                        last_issued_q <= 1'b0;
                        found_nonce_o <= '0;
                        exhausted_o   <= 1'b0;
`ifdef MULTI_HIT_EN
                        hit_count_o   <= '0;
`endif
                    end
                end
                S_RUN: begin
                    if (abort_i) begin
                        aborted_q <= 1'b1;
                    end
                    if (abort_i || last_beat || stop_on_hit) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (abort_i) begin
                        aborted_q <= 1'b1;
                    end
                    if (out_next == '0) begin
                        state       <= S_IDLE;
                        done_o      <= 1'b1;
                        exhausted_o <= last_issued_q && !(hit_seen_q || hit)
                                       && !(aborted_q || abort_i);
                        armed_q     <= 1'b0;
                        in_epoch_q  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    // A counted result with nothing outstanding and no beat this cycle.
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(res_counted && (out_cnt == '0) && !issue));
`endif

endmodule
